fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares the single write port of one fifo_sync instance between N_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter muxes the granted producer onto the FIFO data_in/w_en port and gates all writes on fifo_full.
- Grants are held for bursts of up to MAX_BURST beats so that producers can keep data contiguous.
- Sits directly in front of fifo_sync; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one fifo_sync write port between N_REQ
// valid/ready producers, holding each grant for bursts of up to MAX_BURST beats.
//   state    | meaning
//   ST_IDLE  | no grant held; arbitrate among valid producers
//   ST_BURST | grant_q owns the FIFO write port
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

  logic [0:0]      state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_last_q, rr_last_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  logic [GW:0]           pick;
  logic                  burst_end;
  logic [DATA_WIDTH-1:0] sel_data;

  // Returns {found, index}: first valid bit after base, wrapping, base itself last.
  function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                          input logic [GW-1:0]    base);
    logic [GW:0] res;
    logic        found;
    int          idx;
    res   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(base) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        res   = {1'b1, GW'(idx)};
      end
    end
    return res;
  endfunction

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (k == int'(grant_q)) sel_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_last_d    = rr_last_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    busy         = 1'b0;
    pick         = '0;
    burst_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pick = rr_pick(req_valid, rr_last_q);
        if (pick[GW]) begin
          state_d    = ST_BURST;
          grant_d    = pick[GW-1:0];
          rr_last_d  = pick[GW-1:0];
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        busy               = 1'b1;
        fifo_data_in       = sel_data;
        req_ready[grant_q] = ~fifo_full;
        fifo_w_en          = req_valid[grant_q] & ~fifo_full;
        if (fifo_w_en) beat_cnt_d = beat_cnt_q + 8'd1;
        // fifo_full alone never ends a burst; a dropped valid always does.
        burst_end = ~req_valid[grant_q] | (fifo_w_en & (beat_cnt_q == CNT_LAST));
        if (burst_end) begin
          pick       = rr_pick(req_valid, grant_q);
          beat_cnt_d = '0;
          if (pick[GW]) begin
            grant_d   = pick[GW-1:0];
            rr_last_d = pick[GW-1:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_last_q  <= GW'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_q;

endmodule
